// File: rtl/decode_pkg.sv
// Shared decode definitions: MIPS opcodes, ALUOp encodings and control-bundle bit layout.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   localparam int CB_W        = 9;
   localparam int CB_ALUSRC   = 0;
   localparam int CB_ALUOP0   = 1;
   localparam int CB_ALUOP1   = 2;
   localparam int CB_REGDST   = 3;
   localparam int CB_MEMWRITE = 4;
   localparam int CB_MEMREAD  = 5;
   localparam int CB_BRANCH   = 6;
   localparam int CB_MEMTOREG = 7;
   localparam int CB_REGWRITE = 8;

   typedef logic [CB_W-1:0] ctrl_t;

   function automatic ctrl_t set_aluop(input ctrl_t c, input logic [1:0] aluop);
      ctrl_t r;
      r = c;
      r[CB_ALUOP1] = aluop[1];
      r[CB_ALUOP0] = aluop[0];
      return r;
   endfunction

   // Unsupported opcodes fall through to an all-zero bundle.
   function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
      ctrl_t c;
      c = '0;
      case (opcode)
         OP_RTYPE: begin
            c[CB_REGWRITE] = 1'b1;
            c[CB_REGDST]   = 1'b1;
            c = set_aluop(c, ALUOP_RTYPE);
         end
         OP_LW: begin
            c[CB_REGWRITE] = 1'b1;
            c[CB_MEMTOREG] = 1'b1;
            c[CB_MEMREAD]  = 1'b1;
            c[CB_ALUSRC]   = 1'b1;
            c = set_aluop(c, ALUOP_ADD);
         end
         OP_SW: begin
            c[CB_MEMWRITE] = 1'b1;
            c[CB_ALUSRC]   = 1'b1;
            c = set_aluop(c, ALUOP_ADD);
         end
         OP_BEQ: begin
            c[CB_BRANCH] = 1'b1;
            c = set_aluop(c, ALUOP_BRANCH);
         end
         OP_ADDI: begin
            c[CB_REGWRITE] = 1'b1;
            c[CB_ALUSRC]   = 1'b1;
            c = set_aluop(c, ALUOP_ADD);
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic is_legal(input logic [5:0] opcode);
      return (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
             (opcode == OP_BEQ) || (opcode == OP_ADDI);
   endfunction

endpackage

// File: rtl/regfile_p.sv
// Register file, 2 combinational read ports and 1 write port; register 0 hardwired to zero.
// Optional same-cycle write-to-read bypass so decode sees the value being written back.
module regfile_p #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int REG_AW = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] addr_a,
   input  logic [REG_AW-1:0] addr_b,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      data_a = regs[addr_a];
      if (addr_a == '0) begin
         data_a = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == addr_a)) begin
         data_a = wr_data;
      end
   end

   always_comb begin
      data_b = regs[addr_b];
      if (addr_b == '0) begin
         data_b = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == addr_b)) begin
         data_b = wr_data;
      end
   end

endmodule

// File: rtl/decode_stage_p.sv
// MIPS decode stage: register read, control decode, load-use hazard detect, ID/EX pipeline register.
// ID/EX priority per edge is hold > flush > load-use stall (bubble) > normal load.
module decode_stage_p
   import decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int REG_AW = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_incrementado_in,
   input  logic [31:0]       instruction,
   input  logic              hold,
   input  logic              flush,
   input  logic              RegWrite,
   input  logic [REG_AW-1:0] address_write,
   input  logic [DATA_W-1:0] data_write,
   output logic [31:0]       pc_incrementado_out,
   output logic [DATA_W-1:0] reg_data1,
   output logic [DATA_W-1:0] reg_data2,
   output logic [DATA_W-1:0] sgn_extend_data_imm,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   output logic [REG_AW-1:0] rd,
   output logic              wb_RegWrite_out,
   output logic              wb_MemtoReg_out,
   output logic              m_Branch_out,
   output logic              m_MemRead_out,
   output logic              m_MemWrite_out,
   output logic              ex_RegDst_out,
   output logic              ex_ALUOp0_out,
   output logic              ex_ALUOp1_out,
   output logic              ex_ALUSrc_out,
   output logic              valid_out,
   output logic              stall_out,
   output logic              illegal_out
);

   typedef struct packed {
      logic [31:0]       pc;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      ctrl_t             ctrl;
      logic              valid;
      logic              illegal;
   } idex_t;

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs_f;
   logic [REG_AW-1:0] rt_f;
   logic [REG_AW-1:0] rd_f;
   logic [15:0]       imm16;
   logic [DATA_W-1:0] rf_data1;
   logic [DATA_W-1:0] rf_data2;
   logic              unused_instr_bits;
   idex_t             idex_q;
   idex_t             idex_d;
   idex_t             decoded;

   // Register fields are truncated to the register-file address width.
   assign opcode            = instruction[31:26];
   assign rs_f              = instruction[21 +: REG_AW];
   assign rt_f              = instruction[16 +: REG_AW];
   assign rd_f              = instruction[11 +: REG_AW];
   assign imm16             = instruction[15:0];
   assign unused_instr_bits = ^instruction;

   regfile_p #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .addr_a  (rs_f),
      .addr_b  (rt_f),
      .data_a  (rf_data1),
      .data_b  (rf_data2),
      .wr_en   (RegWrite),
      .wr_addr (address_write),
      .wr_data (data_write)
   );

   always_comb begin
      decoded         = '0;
      decoded.pc      = pc_incrementado_in;
      decoded.data1   = rf_data1;
      decoded.data2   = rf_data2;
      decoded.imm     = {{(DATA_W-16){imm16[15]}}, imm16};
      decoded.rs      = rs_f;
      decoded.rt      = rt_f;
      decoded.rd      = rd_f;
      decoded.ctrl    = decode_ctrl(opcode);
      decoded.valid   = 1'b1;
      decoded.illegal = !is_legal(opcode);
   end

   // A load in ID/EX whose destination feeds the instruction now in decode.
   assign stall_out = idex_q.valid && idex_q.ctrl[CB_MEMREAD] && (idex_q.rt != '0) &&
                      ((idex_q.rt == rs_f) || (idex_q.rt == rt_f));

   always_comb begin
      idex_d = idex_q;
      if (hold) begin
         idex_d = idex_q;
      end else if (flush || stall_out) begin
         idex_d = '0;
      end else begin
         idex_d = decoded;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign pc_incrementado_out = idex_q.pc;
   assign reg_data1           = idex_q.data1;
   assign reg_data2           = idex_q.data2;
   assign sgn_extend_data_imm = idex_q.imm;
   assign rs                  = idex_q.rs;
   assign rt                  = idex_q.rt;
   assign rd                  = idex_q.rd;
   assign wb_RegWrite_out     = idex_q.ctrl[CB_REGWRITE];
   assign wb_MemtoReg_out     = idex_q.ctrl[CB_MEMTOREG];
   assign m_Branch_out        = idex_q.ctrl[CB_BRANCH];
   assign m_MemRead_out       = idex_q.ctrl[CB_MEMREAD];
   assign m_MemWrite_out      = idex_q.ctrl[CB_MEMWRITE];
   assign ex_RegDst_out       = idex_q.ctrl[CB_REGDST];
   assign ex_ALUOp0_out       = idex_q.ctrl[CB_ALUOP0];
   assign ex_ALUOp1_out       = idex_q.ctrl[CB_ALUOP1];
   assign ex_ALUSrc_out       = idex_q.ctrl[CB_ALUSRC];
   assign valid_out           = idex_q.valid;
   assign illegal_out         = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboarded directed bench for decode_stage_p, plus BYPASS=0 and 64-bit/16-register instances.
module tb_decode_stage_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] pc_in, instr, wd;
   logic        hold, flush, we;
   logic [4:0]  wa;

   // control bundle order: RegWrite MemtoReg Branch MemRead MemWrite RegDst ALUOp1 ALUOp0 ALUSrc
   localparam logic [8:0] C_R    = 9'b100001100;
   localparam logic [8:0] C_LW   = 9'b110100001;
   localparam logic [8:0] C_SW   = 9'b000010001;
   localparam logic [8:0] C_BEQ  = 9'b001000010;
   localparam logic [8:0] C_ADDI = 9'b100000001;

   // main DUT (BYPASS=1)
   logic [31:0] pc_out, d1, d2, imm;
   logic [4:0]  rs, rt, rd;
   logic        c_rw, c_mtr, c_br, c_mr, c_mw, c_rdst, c_a0, c_a1, c_as, valid, stall, illegal;
   logic [8:0]  ctrl_a;
   assign ctrl_a = {c_rw, c_mtr, c_br, c_mr, c_mw, c_rdst, c_a1, c_a0, c_as};

   decode_stage_p #(.DATA_W(32), .NREGS(32), .BYPASS(1)) u_bp (
      .clk(clk), .reset(reset), .pc_incrementado_in(pc_in), .instruction(instr),
      .hold(hold), .flush(flush), .RegWrite(we), .address_write(wa), .data_write(wd),
      .pc_incrementado_out(pc_out), .reg_data1(d1), .reg_data2(d2), .sgn_extend_data_imm(imm),
      .rs(rs), .rt(rt), .rd(rd), .wb_RegWrite_out(c_rw), .wb_MemtoReg_out(c_mtr),
      .m_Branch_out(c_br), .m_MemRead_out(c_mr), .m_MemWrite_out(c_mw), .ex_RegDst_out(c_rdst),
      .ex_ALUOp0_out(c_a0), .ex_ALUOp1_out(c_a1), .ex_ALUSrc_out(c_as),
      .valid_out(valid), .stall_out(stall), .illegal_out(illegal));

   // BYPASS=0 instance
   logic [31:0] nb_pc, nb_d1, nb_d2, nb_imm;
   logic [4:0]  nb_rs, nb_rt, nb_rd;
   logic        nb_c0, nb_c1, nb_c2, nb_c3, nb_c4, nb_c5, nb_c6, nb_c7, nb_c8, nb_v, nb_st, nb_il;

   decode_stage_p #(.DATA_W(32), .NREGS(32), .BYPASS(0)) u_nb (
      .clk(clk), .reset(reset), .pc_incrementado_in(pc_in), .instruction(instr),
      .hold(hold), .flush(flush), .RegWrite(we), .address_write(wa), .data_write(wd),
      .pc_incrementado_out(nb_pc), .reg_data1(nb_d1), .reg_data2(nb_d2), .sgn_extend_data_imm(nb_imm),
      .rs(nb_rs), .rt(nb_rt), .rd(nb_rd), .wb_RegWrite_out(nb_c0), .wb_MemtoReg_out(nb_c1),
      .m_Branch_out(nb_c2), .m_MemRead_out(nb_c3), .m_MemWrite_out(nb_c4), .ex_RegDst_out(nb_c5),
      .ex_ALUOp0_out(nb_c6), .ex_ALUOp1_out(nb_c7), .ex_ALUSrc_out(nb_c8),
      .valid_out(nb_v), .stall_out(nb_st), .illegal_out(nb_il));

   // 64-bit, 16-register instance
   logic [63:0] w_wd;
   logic [3:0]  w_wa;
   logic [31:0] w_pc;
   logic [63:0] w_d1, w_d2, w_imm;
   logic [3:0]  w_rs, w_rt, w_rd;
   logic        w_rw, w_mtr, w_br, w_mr, w_mw, w_rdst, w_a0, w_a1, w_as, w_v, w_st, w_il;
   logic [8:0]  w_ctrl;
   assign w_wd   = {32'h0, wd};
   assign w_wa   = wa[3:0];
   assign w_ctrl = {w_rw, w_mtr, w_br, w_mr, w_mw, w_rdst, w_a1, w_a0, w_as};

   decode_stage_p #(.DATA_W(64), .NREGS(16), .BYPASS(1)) u_w (
      .clk(clk), .reset(reset), .pc_incrementado_in(pc_in), .instruction(instr),
      .hold(hold), .flush(flush), .RegWrite(we), .address_write(w_wa), .data_write(w_wd),
      .pc_incrementado_out(w_pc), .reg_data1(w_d1), .reg_data2(w_d2), .sgn_extend_data_imm(w_imm),
      .rs(w_rs), .rt(w_rt), .rd(w_rd), .wb_RegWrite_out(w_rw), .wb_MemtoReg_out(w_mtr),
      .m_Branch_out(w_br), .m_MemRead_out(w_mr), .m_MemWrite_out(w_mw), .ex_RegDst_out(w_rdst),
      .ex_ALUOp0_out(w_a0), .ex_ALUOp1_out(w_a1), .ex_ALUSrc_out(w_as),
      .valid_out(w_v), .stall_out(w_st), .illegal_out(w_il));

   // scoreboard
   typedef struct { int cyc; int id; logic [153:0] v; } oexp_t;
   typedef struct { int cyc; int id; logic v; } sexp_t;
   oexp_t oq[$];
   sexp_t sq[$];
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic [153:0] act;
   assign act = {pc_out, d1, d2, imm, rs, rt, rd, ctrl_a, valid, illegal};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, a, e);
      end
   endtask

   task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic h, input logic f,
                        input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic exp_stall, input int id);
      @(posedge clk);
      #1;
      pc_in = p; instr = i; hold = h; flush = f; we = w; wa = a; wd = d;
      sq.push_back('{cyc, id, exp_stall});
   endtask

   task automatic expect_out(input int id, input logic [31:0] p, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] ei, input logic [4:0] ers,
                             input logic [4:0] ert, input logic [4:0] erd, input logic [8:0] ec,
                             input logic ev, input logic eil);
      oq.push_back('{cyc, id, {p, e1, e2, ei, ers, ert, erd, ec, ev, eil}});
   endtask

   // monitor: stall is compared in the cycle it was driven, ID/EX after the following edge
   initial begin
      sexp_t s;
      oexp_t o;
      forever begin
         @(negedge clk);
         while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            checks++;
            if (stall !== s.v) begin
               errors++;
               $display("FAIL stall vec %0d: got %b want %b", s.id, stall, s.v);
            end
         end
         while (oq.size() > 0 && oq[0].cyc < cyc) begin
            o = oq.pop_front();
            checks++;
            if (act !== o.v) begin
               errors++;
               $display("FAIL idex vec %0d: got %h want %h", o.id, act, o.v);
            end
         end
      end
   end

   initial begin
      reset = 1'b0; pc_in = '0; instr = '0; hold = 1'b0; flush = 1'b0;
      we = 1'b0; wa = '0; wd = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_pc", {32'd0, pc_out}, 64'd0);
      chk("rst_ctrl", {55'd0, ctrl_a}, 64'd0);
      chk("rst_d1", {32'd0, d1}, 64'd0);
      chk("rst_w_valid", {63'd0, w_v}, 64'd0);
      reset = 1'b1;

      // write r4=1024 under a NOP (opcode 0 decodes as R-type)
      drive(32'h100, 32'h00000000, 0, 0, 1, 5'd4, 32'd1024, 0, 1);
      expect_out(1, 32'h100, 0, 0, 0, 0, 0, 0, C_R, 1, 0);
      drive(32'h104, 32'hAC840000, 0, 0, 0, 0, 0, 0, 2);
      expect_out(2, 32'h104, 1024, 1024, 0, 4, 4, 0, C_SW, 1, 0);
      drive(32'h108, 32'h10840000, 0, 0, 0, 0, 0, 0, 3);
      expect_out(3, 32'h108, 1024, 1024, 0, 4, 4, 0, C_BEQ, 1, 0);
      drive(32'h10C, 32'h8C840000, 0, 0, 0, 0, 0, 0, 4);
      expect_out(4, 32'h10C, 1024, 1024, 0, 4, 4, 0, C_LW, 1, 0);
      // add r5,r4,r4 behind lw r4: one stall, bubble, then reissue
      drive(32'h110, 32'h00842820, 0, 0, 0, 0, 0, 1, 5);
      expect_out(5, 0, 0, 0, 0, 0, 0, 0, 9'd0, 0, 0);
      chk("w64_lw_d1", w_d1, 64'd1024);
      chk("w64_lw_ctrl", {55'd0, w_ctrl}, {55'd0, C_LW});
      chk("w64_lw_rs", {60'd0, w_rs}, 64'd4);
      drive(32'h110, 32'h00842820, 0, 0, 0, 0, 0, 0, 6);
      expect_out(6, 32'h110, 1024, 1024, 32'h2820, 4, 4, 5, C_R, 1, 0);
      drive(32'h114, 32'h2084FFFF, 0, 0, 0, 0, 0, 0, 7);
      expect_out(7, 32'h114, 1024, 1024, 32'hFFFFFFFF, 4, 4, 31, C_ADDI, 1, 0);
      // same-cycle write of r7 while reading r7
      drive(32'h118, 32'h00E04020, 0, 0, 1, 5'd7, 32'hDEAD, 0, 8);
      expect_out(8, 32'h118, 32'hDEAD, 0, 32'h4020, 7, 0, 8, C_R, 1, 0);
      chk("w64_imm_sext", w_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      // write to r0 must not bypass nor store
      drive(32'h11C, 32'h00074820, 0, 0, 1, 5'd0, 32'h1234, 0, 9);
      expect_out(9, 32'h11C, 0, 32'hDEAD, 32'h4820, 0, 7, 9, C_R, 1, 0);
      chk("nobypass_old_r7", {32'd0, nb_d1}, 64'd0);
      drive(32'h120, 32'h00005020, 0, 0, 0, 0, 0, 0, 10);
      expect_out(10, 32'h120, 0, 0, 32'h5020, 0, 0, 10, C_R, 1, 0);
      chk("nobypass_r7_later", {32'd0, nb_d2}, 64'hDEAD);
      drive(32'h124, 32'hAC840000, 0, 0, 0, 0, 0, 0, 11);
      expect_out(11, 32'h124, 1024, 1024, 0, 4, 4, 0, C_SW, 1, 0);
      // hold beats flush
      drive(32'h128, 32'h10840000, 1, 1, 0, 0, 0, 0, 12);
      expect_out(12, 32'h124, 1024, 1024, 0, 4, 4, 0, C_SW, 1, 0);
      drive(32'h12C, 32'h10840000, 0, 1, 0, 0, 0, 0, 13);
      expect_out(13, 0, 0, 0, 0, 0, 0, 0, 9'd0, 0, 0);
      drive(32'h130, 32'hFC000000, 0, 0, 0, 0, 0, 0, 14);
      expect_out(14, 32'h130, 0, 0, 0, 0, 0, 0, 9'd0, 1, 1);
      drive(32'h134, 32'h8C840000, 0, 0, 0, 0, 0, 0, 15);
      expect_out(15, 32'h134, 1024, 1024, 0, 4, 4, 0, C_LW, 1, 0);
      // hazard under hold: stall still reported, ID/EX frozen
      drive(32'h138, 32'h00842820, 1, 0, 0, 0, 0, 1, 16);
      expect_out(16, 32'h134, 1024, 1024, 0, 4, 4, 0, C_LW, 1, 0);
      drive(32'h138, 32'h00842820, 0, 0, 0, 0, 0, 1, 17);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_valid", {63'd0, valid}, 64'd0);
      chk("arst_stall", {63'd0, stall}, 64'd0);
      chk("arst_pc", {32'd0, pc_out}, 64'd0);
      chk("arst_ctrl", {55'd0, ctrl_a}, 64'd0);
      chk("arst_d1", {32'd0, d1}, 64'd0);
      chk("arst_w_valid", {63'd0, w_v}, 64'd0);
      // first edge after release loads normally; register file was cleared
      drive(32'h200, 32'h8C840000, 0, 0, 0, 0, 0, 0, 18);
      reset = 1'b1;
      expect_out(18, 32'h200, 0, 0, 0, 4, 4, 0, C_LW, 1, 0);
      drive(32'h204, 32'h00000000, 0, 0, 0, 0, 0, 0, 19);

      for (int k = 0; k < 10; k++) begin
         if (oq.size() == 0 && sq.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      if (oq.size() != 0 || sq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d outputs and %0d stalls still pending, want 0", oq.size(), sq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath/register width (32 or 64).
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, 8..32); REG_AW = log2(NREGS).
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read bypass enabled.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pc_incrementado_in  in  32  PC+4 of the instruction in decode.
REQ-007 instruction  in  32  MIPS instruction word.
REQ-008 hold  in  1  downstream freeze; ID/EX register keeps its contents.
REQ-009 flush  in  1  taken branch; current decode slot is squashed.
REQ-010 RegWrite / address_write / data_write  in  1 / REG_AW / DATA_W  write-back port.
REQ-011 pc_incrementado_out  out  32  registered PC+4.
REQ-012 reg_data1, reg_data2, sgn_extend_data_imm  out  DATA_W each  registered rs/rt data, sign-extended imm[15:0].
REQ-013 rs, rt, rd  out  REG_AW each  registered register fields (truncated to REG_AW).
REQ-014 wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUOp0_out, ex_ALUOp1_out, ex_ALUSrc_out  out  1 each  registered control bundle.
REQ-015 valid_out  out  1  ID/EX holds a real instruction (0 = bubble).
REQ-016 stall_out  out  1  combinational; upstream freezes PC and IF/ID this cycle.
REQ-017 illegal_out  out  1  registered; unsupported opcode was decoded.

Function
REQ-018 Register file SHALL write data_write to address_write on rising edge when RegWrite=1 and address_write!=0; register 0 SHALL always read 0.
REQ-019 With BYPASS=1, a read of address A while RegWrite=1, address_write=A, A!=0 SHALL return data_write in the same cycle.
REQ-020 Decode SHALL map opcode: 000000 R-type (RegWrite, RegDst, ALUOp=10); 100011 lw (RegWrite, MemtoReg, MemRead, ALUSrc, ALUOp=00); 101011 sw (MemWrite, ALUSrc, ALUOp=00); 000100 beq (Branch, ALUOp=01); 001000 addi (RegWrite, ALUSrc, ALUOp=00); ALUOp1 = bit1, ALUOp0 = bit0.
REQ-021 Any other opcode SHALL produce an all-zero control bundle, valid_out=1, illegal_out=1.
REQ-022 Load-use hazard: stall_out=1 when valid_out=1, m_MemRead_out=1, rt!=0, and rt equals instruction[25:21] or instruction[20:16] (field compare on low REG_AW bits); otherwise 0.
REQ-023 ID/EX update priority per edge: hold > flush > stall_out > normal load.
REQ-024 hold=1: all registered outputs unchanged; stall_out still evaluated.
REQ-025 flush=1 (hold=0): next state is bubble (valid_out=0, control bundle 0, illegal_out=0); data fields don't-care but SHALL be zeroed.
REQ-026 stall_out=1 (hold=0, flush=0): bubble inserted; upstream re-presents the same instruction next cycle.
REQ-027 Normal: all outputs load from current decode; latency instruction -> outputs exactly 1 cycle.
REQ-028 Sign extension SHALL replicate imm[15] to DATA_W bits.

Reset
REQ-029 reset=0 SHALL asynchronously clear all ID/EX outputs to 0 (valid_out=0) and all registers to 0.
REQ-030 Reset asserted mid-stall or mid-hold SHALL override both; first post-reset edge loads normally.

Structure
REQ-031 Opcode constants, ALUOp encodings and control-bundle field positions SHALL live in shared package decode_pkg.
REQ-032 Register file SHALL be sub-module regfile_p (parameters DATA_W, NREGS, BYPASS; 2 read, 1 write).
REQ-033 Hazard detection and decode SHALL be combinational logic in decode_stage_p.

Verification
REQ-034 Write r4=1024 (RegWrite pulse), then 0x8C840000 (lw r4,0(r4)) -> next cycle reg_data1=1024, MemRead=MemtoReg=ALUSrc=RegWrite=1, ALUOp=00.
REQ-035 0xAC840000 then 0x10840000 -> sw bundle (MemWrite, ALUSrc) then beq bundle (Branch, ALUOp=01), reg_data2=1024 both.
REQ-036 lw r4 then R-type add r5,r4,r4 -> stall_out=1 one cycle, valid_out=0 bubble, add issued next cycle.
REQ-037 Same-cycle write r7=0xDEAD with read of r7 -> reg_data1=0xDEAD (BYPASS=1), old value (BYPASS=0); write to r0 -> reads 0.
REQ-038 flush with hold simultaneous -> outputs unchanged; hold released with flush -> bubble; opcode 111111 -> illegal_out=1, bundle 0.
REQ-039 Async reset asserted mid-stall -> all outputs 0 immediately; rerun REQ-034 with DATA_W=64, NREGS=16.
